// File: rtl/fir_pkg.sv
// Shared types and default sizing for the FIR MAC scheduler slice.
package fir_pkg;

    localparam int defaultNTaps      = 9;
    localparam int defaultMulLatency = 2;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        MAC,
        DRAIN,
        DONE
    } firState_e;

endpackage

// File: rtl/fir_ring_ptr.sv
// Modulo-NTaps ring arithmetic: head increment and head-minus-tap read address.
module fir_ring_ptr #(
    parameter int NTaps     = 9,
    parameter int AddrWidth = 4
) (
    input  logic [AddrWidth-1:0] head,
    input  logic [AddrWidth-1:0] tapIdx,
    output logic [AddrWidth-1:0] headNext,
    output logic [AddrWidth-1:0] rdAddr
);

    localparam logic [AddrWidth-1:0] lastIdx  = AddrWidth'(NTaps - 1);
    localparam logic [AddrWidth-1:0] ringSize = AddrWidth'(NTaps);

    // Adding NTaps on underflow keeps the result inside 0..NTaps-1 even for non-power-of-two rings.
    always_comb begin
        headNext = (head == lastIdx) ? '0 : head + AddrWidth'(1);
        rdAddr   = head - tapIdx + ((head < tapIdx) ? ringSize : '0);
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Sequences one FIR output sample: delay-line write, NTaps MAC reads, multiplier drain, done.
module fir_mac_scheduler
    import fir_pkg::*;
#(
    parameter int   NTaps      = defaultNTaps,
    parameter int   MulLatency = defaultMulLatency,
    localparam int  AddrWidth  = ($clog2(NTaps) > 1) ? $clog2(NTaps) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 lock,
    input  logic                 coeffLoadIn,
    output logic                 wrEn,
    output logic [AddrWidth-1:0] wrAddr,
    output logic [AddrWidth-1:0] rdAddr,
    output logic [AddrWidth-1:0] coeffIdx,
    output logic                 accEn,
    output logic                 accClear,
    output logic                 done,
    output logic                 busy,
    output logic                 coeffShiftEn,
    output logic                 overrun
);

    localparam logic [AddrWidth-1:0] lastTap = AddrWidth'(NTaps - 1);

    firState_e state, nextState;

    logic [AddrWidth-1:0] head, headNext, tapIdx, ringRdAddr;
    logic [AddrWidth-1:0] wrAddrHold, rdAddrHold, coeffIdxHold;
    logic                 pending, overrunQ, drainLast;
    logic [MulLatency-1:0] accPipe, clrPipe;

    fir_ring_ptr #(
        .NTaps    (NTaps),
        .AddrWidth(AddrWidth)
    ) ringPtr (
        .head    (head),
        .tapIdx  (tapIdx),
        .headNext(headNext),
        .rdAddr  (ringRdAddr)
    );

    // The last drain cycle is the one where the final MAC token sits alone at the pipe output.
    always_comb begin
        drainLast = accPipe[MulLatency-1];
        for (int k = 0; k < MulLatency - 1; k++) begin
            if (accPipe[k]) drainLast = 1'b0;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if ((start || pending) && !lock) nextState = WRITE;
            WRITE:   nextState = MAC;
            MAC:     if (tapIdx == lastTap) nextState = DRAIN;
            DRAIN:   if (drainLast) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // A start is only kept when it lands in IDLE with the pending slot free; anything else is an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head         <= '0;
            tapIdx       <= '0;
            pending      <= 1'b0;
            overrunQ     <= 1'b0;
            wrAddrHold   <= '0;
            rdAddrHold   <= '0;
            coeffIdxHold <= '0;
        end else begin
            overrunQ <= start && ((state != IDLE) || pending);
            if (state == IDLE) pending <= lock ? (pending || start) : 1'b0;
            case (state)
                WRITE: begin
                    wrAddrHold <= head;
                    tapIdx     <= '0;
                end
                MAC: begin
                    rdAddrHold   <= ringRdAddr;
                    coeffIdxHold <= tapIdx;
                    tapIdx       <= (tapIdx == lastTap) ? '0 : tapIdx + AddrWidth'(1);
                end
                DONE:    head <= headNext;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accPipe <= '0;
            clrPipe <= '0;
        end else begin
            accPipe[0] <= (state == MAC);
            clrPipe[0] <= (state == MAC) && (tapIdx == '0);
            for (int k = 1; k < MulLatency; k++) begin
                accPipe[k] <= accPipe[k-1];
                clrPipe[k] <= clrPipe[k-1];
            end
        end
    end

    always_comb begin
        wrEn         = (state == WRITE);
        wrAddr       = (state == WRITE) ? head : wrAddrHold;
        rdAddr       = (state == MAC) ? ringRdAddr : rdAddrHold;
        coeffIdx     = (state == MAC) ? tapIdx : coeffIdxHold;
        accEn        = accPipe[MulLatency-1];
        accClear     = clrPipe[MulLatency-1];
        done         = (state == DONE);
        busy         = (state != IDLE);
        coeffShiftEn = coeffLoadIn && (state == IDLE);
        overrun      = overrunQ;
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Scoreboard bench: a cycle-timing reference model queues expected events, a negedge monitor checks them.
module tb_fir_mac_scheduler;

    localparam int NT = 9;
    localparam int ML = 2;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          lock = 1'b0;
    logic          coeffLoadIn = 1'b0;
    logic          wrEn, accEn, accClear, done, busy, coeffShiftEn, overrun;
    logic [AW-1:0] wrAddr, rdAddr, coeffIdx;

    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    ev_t wrQ[$], rdQ[$], accQ[$], doneQ[$], ovQ[$], shQ[$];
    ev_t e;
    bit  expNow;

    int cycle = 0;
    int testsRun = 0;
    int failures = 0;
    int mHead = 0;
    bit mPending = 1'b0;
    int busyFrom = 0;
    int busyUntil = -1;
    bit lockVal = 1'b0;

    fir_mac_scheduler #(
        .NTaps     (NT),
        .MulLatency(ML)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .lock        (lock),
        .coeffLoadIn (coeffLoadIn),
        .wrEn        (wrEn),
        .wrAddr      (wrAddr),
        .rdAddr      (rdAddr),
        .coeffIdx    (coeffIdx),
        .accEn       (accEn),
        .accClear    (accClear),
        .done        (done),
        .busy        (busy),
        .coeffShiftEn(coeffShiftEn),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic int pack(input bit seen, input int a, input int b);
        return (seen ? 65536 : 0) + a * 256 + b;
    endfunction

    task automatic checkOutput(input string name, input bit ok, input int act, input int exp);
        testsRun++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got 'h%0h, want 'h%0h", name, cycle, act, exp);
        end
    endtask

    task automatic scoreEvent(input string name, input bit seen, input int a, input int b,
                              input bit due, input ev_t x);
        if (seen || due)
            checkOutput(name, (seen == due) && (!seen || (a == x.a && b == x.b)),
                        pack(seen, a, b), pack(due, x.a, x.b));
    endtask

    // One run launched with its write in cycle w: every output event follows from fixed offsets.
    task automatic launchRun(input int w);
        wrQ.push_back('{w, mHead, 0});
        for (int t = 0; t < NT; t++) begin
            rdQ.push_back('{w + 1 + t, (mHead - t + NT) % NT, t});
            accQ.push_back('{w + 1 + t + ML, (t == 0) ? 1 : 0, 1});
        end
        doneQ.push_back('{w + NT + ML + 1, 0, 0});
        busyFrom  = w;
        busyUntil = w + NT + ML + 1;
        mHead     = (mHead + 1) % NT;
    endtask

    task automatic applyStimulus(input bit s, input bit l, input bit cl);
        start       = s;
        lock        = l;
        coeffLoadIn = cl;
        if (cycle <= busyUntil) begin
            if (s) ovQ.push_back('{cycle + 1, 0, 0});
        end else begin
            if (cl) shQ.push_back('{cycle, 0, 0});
            if (l) begin
                if (s && mPending) ovQ.push_back('{cycle + 1, 0, 0});
                else if (s) mPending = 1'b1;
            end else if (s || mPending) begin
                if (s && mPending) ovQ.push_back('{cycle + 1, 0, 0});
                launchRun(cycle + 1);
                mPending = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset       = 1'b1;
        start       = 1'b0;
        lock        = 1'b0;
        coeffLoadIn = 1'b0;
        #1;
        checkOutput("resetOutputs",
                    {wrEn, wrAddr, rdAddr, coeffIdx, accEn, accClear, done, busy, coeffShiftEn, overrun} == '0,
                    int'({wrEn, wrAddr, rdAddr, coeffIdx, accEn, accClear, done, busy, coeffShiftEn, overrun}), 0);
        wrQ.delete(); rdQ.delete(); accQ.delete(); doneQ.delete(); ovQ.delete(); shQ.delete();
        mHead     = 0;
        mPending  = 1'b0;
        busyFrom  = 0;
        busyUntil = -1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("busy", busy == (cycle >= busyFrom && cycle <= busyUntil), int'(busy),
                        (cycle >= busyFrom && cycle <= busyUntil) ? 1 : 0);

            expNow = wrQ.size() > 0 && wrQ[0].cyc == cycle;
            if (expNow) e = wrQ[0]; else e = '{0, 0, 0};
            scoreEvent("write", wrEn, int'(wrAddr), 0, expNow, e);
            if (expNow) void'(wrQ.pop_front());

            expNow = rdQ.size() > 0 && rdQ[0].cyc == cycle;
            if (expNow) begin
                checkOutput("rdAddr/coeffIdx", rdAddr == AW'(rdQ[0].a) && coeffIdx == AW'(rdQ[0].b),
                            pack(1'b1, int'(rdAddr), int'(coeffIdx)), pack(1'b1, rdQ[0].a, rdQ[0].b));
                void'(rdQ.pop_front());
            end

            expNow = accQ.size() > 0 && accQ[0].cyc == cycle;
            if (expNow) e = accQ[0]; else e = '{0, 0, 0};
            scoreEvent("accEn/accClear", accEn || accClear, int'(accClear), int'(accEn), expNow, e);
            if (expNow) void'(accQ.pop_front());

            expNow = doneQ.size() > 0 && doneQ[0].cyc == cycle;
            if (expNow) e = doneQ[0]; else e = '{0, 0, 0};
            scoreEvent("done", done, 0, 0, expNow, e);
            if (expNow) void'(doneQ.pop_front());

            expNow = ovQ.size() > 0 && ovQ[0].cyc == cycle;
            if (expNow) e = ovQ[0]; else e = '{0, 0, 0};
            scoreEvent("overrun", overrun, 0, 0, expNow, e);
            if (expNow) void'(ovQ.pop_front());

            expNow = shQ.size() > 0 && shQ[0].cyc == cycle;
            if (expNow) e = shQ[0]; else e = '{0, 0, 0};
            scoreEvent("coeffShiftEn", coeffShiftEn, 0, 0, expNow, e);
            if (expNow) void'(shQ.pop_front());
        end
    end

    initial begin
        int leftover;
        doReset();

        // Single run with the start presented in cycle 10.
        while (cycle < 10) applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        repeat (19) applyStimulus(0, 0, 0);

        // Ten runs spaced 16 cycles apart walk the ring head through 1..8, 0, 1.
        for (int r = 0; r < 10; r++) begin
            applyStimulus(1, 0, 0);
            repeat (15) applyStimulus(0, 0, 0);
        end

        // Starts mid-run and in DONE are dropped; the first IDLE cycle accepts again.
        applyStimulus(1, 0, 0);
        repeat (4) applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        repeat (7) applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        repeat (20) applyStimulus(0, 0, 0);

        // Start coincident with lock rising goes pending; a second start under lock overruns.
        applyStimulus(1, 1, 0);
        repeat (4) applyStimulus(0, 1, 0);
        applyStimulus(1, 1, 0);
        repeat (14) applyStimulus(0, 1, 0);
        repeat (20) applyStimulus(0, 0, 0);

        // Coefficient shift requests pass only while idle.
        applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        repeat (16) applyStimulus(0, 0, 0);

        // Reset during MAC at tap 4, then the next run restarts at address 0.
        applyStimulus(1, 0, 0);
        repeat (5) applyStimulus(0, 0, 0);
        doReset();
        repeat (3) applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        repeat (20) applyStimulus(0, 0, 0);

        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 24) == 0) lockVal = !lockVal;
            applyStimulus($urandom_range(0, 5) == 0, lockVal, $urandom_range(0, 7) == 0);
        end
        repeat (40) applyStimulus(0, 0, 0);

        leftover = wrQ.size() + rdQ.size() + accQ.size() + doneQ.size() + ovQ.size() + shQ.size();
        checkOutput("queuesDrained", leftover == 0, leftover, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
